// File: rtl/ac97_reg_access_if.sv
// Host-side command/response bus for the AC97 codec register access block.
//   master : host; drives cmd_valid/cmd_write/cmd_addr/cmd_wdata, sees
//            cmd_ready and the rsp_valid/rsp_data/rsp_timeout completion.
//   slave  : ac97_reg_access; the mirror image.
interface ac97_reg_access_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/ac97_reg_access.sv
// AC97 codec register access engine.
// Takes one host read/write command at a time, places it into the outgoing
// command-address/command-data slots for exactly one AC-link frame, then
// either completes (write) or watches incoming status slots for the echoed
// register index (read), giving up after TIMEOUT_FRAMES frames.
// Ports:
//   ac97_bitclk / ac97_rst      : clock, synchronous active-high reset
//   ac97_strobe                 : one-cycle pulse per 256-bit frame
//   ac97_in_tag/slot1/slot2     : received TAG/status slots, valid on strobe
//   ac97_out_slot1/2 (+_valid)  : command slots to the link stage
//   codec_ready                 : TAG bit15 captured on each strobe
//   bus (slave)                 : host command/response handshake
module ac97_reg_access #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        ac97_bitclk,
  input  logic        ac97_rst,
  input  logic        ac97_strobe,
  input  logic [15:0] ac97_in_tag,
  input  logic [19:0] ac97_in_slot1,
  input  logic [19:0] ac97_in_slot2,
  output logic [19:0] ac97_out_slot1,
  output logic        ac97_out_slot1_valid,
  output logic [19:0] ac97_out_slot2,
  output logic        ac97_out_slot2_valid,
  output logic        codec_ready,
  ac97_reg_access_if.slave bus
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {IDLE, ARM, SEND, WAIT} state_t;

  state_t      state, state_n;
  logic        lat_write, lat_write_n;
  logic [6:0]  lat_addr, lat_addr_n;
  logic [15:0] lat_wdata, lat_wdata_n;
  logic [7:0]  cnt, cnt_n, cnt_inc;
  logic [19:0] slot1_n, slot2_n;
  logic        slot1_v_n, slot2_v_n;
  logic        codec_ready_n;
  logic        rsp_valid_n, rsp_timeout_n;
  logic [15:0] rsp_data_n;
  logic        match;

  // Status bits this block never looks at.
  logic unused_bits;
  assign unused_bits = ^{ac97_in_tag[13:0], ac97_in_slot1[19], ac97_in_slot1[11:0],
                         ac97_in_slot2[3:0]};

  // Built only from registers, so no input-to-output combinational path.
  assign bus.cmd_ready = (state == IDLE) && codec_ready;

  always_comb begin
    state_n       = state;
    lat_write_n   = lat_write;
    lat_addr_n    = lat_addr;
    lat_wdata_n   = lat_wdata;
    cnt_n         = cnt;
    cnt_inc       = cnt + 8'd1;
    slot1_n       = ac97_out_slot1;
    slot2_n       = ac97_out_slot2;
    slot1_v_n     = ac97_out_slot1_valid;
    slot2_v_n     = ac97_out_slot2_valid;
    rsp_valid_n   = 1'b0;
    rsp_data_n    = bus.rsp_data;
    rsp_timeout_n = bus.rsp_timeout;
    codec_ready_n = ac97_strobe ? ac97_in_tag[15] : codec_ready;
    match         = ac97_in_tag[14] && (ac97_in_slot1[18:12] == lat_addr);

    case (state)
      IDLE: begin
        // A strobe on the accept edge is never seen by ARM: ARM is entered
        // on this edge and only acts on a later strobe.
        if (bus.cmd_valid && bus.cmd_ready) begin
          lat_write_n = bus.cmd_write;
          lat_addr_n  = bus.cmd_addr;
          lat_wdata_n = bus.cmd_wdata;
          state_n     = ARM;
        end
      end
      ARM: begin
        if (ac97_strobe) begin
          // slot1 bit19 is the read flag (1 = read).
          slot1_n   = {~lat_write, lat_addr, 12'h000};
          slot1_v_n = 1'b1;
          slot2_n   = lat_write ? {lat_wdata, 4'h0} : 20'h0;
          slot2_v_n = lat_write;
          state_n   = SEND;
        end
      end
      SEND: begin
        if (ac97_strobe) begin
          slot1_n   = 20'h0;
          slot2_n   = 20'h0;
          slot1_v_n = 1'b0;
          slot2_v_n = 1'b0;
          if (lat_write) begin
            rsp_valid_n   = 1'b1;
            rsp_data_n    = 16'h0000;
            rsp_timeout_n = 1'b0;
            state_n       = IDLE;
          end else begin
            cnt_n   = 8'd0;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (ac97_strobe) begin
          // A match on the final allowed frame still wins over timeout.
          if (match) begin
            rsp_valid_n   = 1'b1;
            rsp_data_n    = ac97_in_slot2[19:4];
            rsp_timeout_n = 1'b0;
            state_n       = IDLE;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == TO_CNT) begin
              rsp_valid_n   = 1'b1;
              rsp_data_n    = 16'hFFFF;
              rsp_timeout_n = 1'b1;
              state_n       = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ac97_bitclk) begin
    if (ac97_rst) begin
      state                <= IDLE;
      lat_write            <= 1'b0;
      lat_addr             <= '0;
      lat_wdata            <= '0;
      cnt                  <= '0;
      ac97_out_slot1       <= '0;
      ac97_out_slot2       <= '0;
      ac97_out_slot1_valid <= 1'b0;
      ac97_out_slot2_valid <= 1'b0;
      codec_ready          <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_data         <= '0;
      bus.rsp_timeout      <= 1'b0;
    end else begin
      state                <= state_n;
      lat_write            <= lat_write_n;
      lat_addr             <= lat_addr_n;
      lat_wdata            <= lat_wdata_n;
      cnt                  <= cnt_n;
      ac97_out_slot1       <= slot1_n;
      ac97_out_slot2       <= slot2_n;
      ac97_out_slot1_valid <= slot1_v_n;
      ac97_out_slot2_valid <= slot2_v_n;
      codec_ready          <= codec_ready_n;
      bus.rsp_valid        <= rsp_valid_n;
      bus.rsp_data         <= rsp_data_n;
      bus.rsp_timeout      <= rsp_timeout_n;
    end
  end

endmodule

// File: tb/tb_ac97_reg_access.sv
// Bench for ac97_reg_access: directed register transactions from the data
// sheet examples plus randomized reads/writes scored against a frame-level
// model of the expected completion.
module tb_ac97_reg_access;
  localparam int TO = 4;

  typedef struct packed {
    logic [15:0] tag;
    logic [19:0] s1;
    logic [19:0] s2;
  } frame_t;

  logic        ac97_bitclk = 1'b0;
  logic        ac97_rst    = 1'b1;
  logic        ac97_strobe = 1'b0;
  logic [15:0] ac97_in_tag = '0;
  logic [19:0] ac97_in_slot1 = '0;
  logic [19:0] ac97_in_slot2 = '0;
  logic [19:0] ac97_out_slot1, ac97_out_slot2;
  logic        ac97_out_slot1_valid, ac97_out_slot2_valid;
  logic        codec_ready;

  ac97_reg_access_if bus();

  ac97_reg_access #(.TIMEOUT_FRAMES(TO)) dut (
    .ac97_bitclk         (ac97_bitclk),
    .ac97_rst            (ac97_rst),
    .ac97_strobe         (ac97_strobe),
    .ac97_in_tag         (ac97_in_tag),
    .ac97_in_slot1       (ac97_in_slot1),
    .ac97_in_slot2       (ac97_in_slot2),
    .ac97_out_slot1      (ac97_out_slot1),
    .ac97_out_slot1_valid(ac97_out_slot1_valid),
    .ac97_out_slot2      (ac97_out_slot2),
    .ac97_out_slot2_valid(ac97_out_slot2_valid),
    .codec_ready         (codec_ready),
    .bus                 (bus.slave)
  );

  always #5 ac97_bitclk = ~ac97_bitclk;

  int     checks = 0;
  int     errors = 0;
  int     rsp_cnt = 0;
  frame_t fr [TO];

  // Completion pulses counted on the sampling edge.
  always @(negedge ac97_bitclk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ac97_in_tag   = 16'($urandom);
      ac97_in_slot1 = 20'($urandom);
      ac97_in_slot2 = 20'($urandom);
      @(negedge ac97_bitclk);
    end
  endtask

  // Idle gap (with garbage on the slot inputs), then one strobe cycle.
  task automatic strobe(input logic [15:0] tag, input logic [19:0] s1,
                        input logic [19:0] s2, input int gap);
    ac97_strobe = 1'b0;
    idle(gap);
    ac97_strobe   = 1'b1;
    ac97_in_tag   = tag;
    ac97_in_slot1 = s1;
    ac97_in_slot2 = s2;
    @(negedge ac97_bitclk);
    ac97_strobe   = 1'b0;
    ac97_in_tag   = 16'($urandom);
    ac97_in_slot1 = 20'($urandom);
    ac97_in_slot2 = 20'($urandom);
  endtask

  // Expected read completion: first of the TO frames whose TAG slot1-valid
  // is set and whose echoed index is ours; otherwise timeout on frame TO.
  function automatic void model_read(input logic [6:0] a, output int k,
                                     output logic [15:0] d, output logic to);
    logic found = 1'b0;
    k = TO - 1; d = 16'hFFFF; to = 1'b1;
    for (int i = 0; i < TO; i++)
      if (!found && fr[i].tag[14] && fr[i].s1[18:12] == a) begin
        found = 1'b1; k = i; d = fr[i].s2[19:4]; to = 1'b0;
      end
  endfunction

  task automatic issue(input logic w, input logic [6:0] a, input logic [15:0] d,
                       input bit with_strb, input string nm);
    int n = 0;
    if (bus.cmd_ready !== 1'b1) strobe(16'h8000, 20'h0, 20'h0, 2);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(negedge ac97_bitclk); n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL %s_ready_wait got cmd_ready=%b exp 1 within 50 cycles", nm, bus.cmd_ready);
    end
    if (with_strb) begin
      ac97_strobe = 1'b1; ac97_in_tag = 16'hE000; ac97_in_slot1 = {1'b0, a, 12'h0};
    end
    @(negedge ac97_bitclk);
    ac97_strobe = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom);
    bus.cmd_addr = 7'($urandom); bus.cmd_wdata = 16'($urandom);
    checks++;
    if ({bus.cmd_ready, ac97_out_slot1_valid} !== 2'b00) begin
      errors++;
      $display("FAIL %s_accept got ready,s1v=%b%b exp 00", nm, bus.cmd_ready, ac97_out_slot1_valid);
    end
  endtask

  task automatic run_txn(input logic w, input logic [6:0] a, input logic [15:0] d,
                         input bit with_strb, input string nm);
    logic [41:0] exp_slots, got_slots;
    int ek, pre;
    logic [15:0] ed;
    logic eto;
    issue(w, a, d, with_strb, nm);
    // ARM frame carries a matching-looking status echo that must be ignored.
    strobe(16'hC000, {1'b0, a, 12'h0}, 20'hABCD0, 1 + $urandom_range(0, 3));
    exp_slots = {1'b1, ~w, a, 12'h000, w, (w ? {d, 4'h0} : 20'h0)};
    got_slots = {ac97_out_slot1_valid, ac97_out_slot1, ac97_out_slot2_valid, ac97_out_slot2};
    checks++;
    if (got_slots !== exp_slots || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_arm got %h rv=%b exp %h rv=0", nm, got_slots, bus.rsp_valid, exp_slots);
    end
    idle(2 + $urandom_range(0, 4));
    got_slots = {ac97_out_slot1_valid, ac97_out_slot1, ac97_out_slot2_valid, ac97_out_slot2};
    checks++;
    if (got_slots !== exp_slots) begin
      errors++;
      $display("FAIL %s_hold got %h exp %h", nm, got_slots, exp_slots);
    end
    pre = rsp_cnt;
    strobe(16'hC000, {1'b0, a, 12'h0}, 20'h12340, 1);
    got_slots = {ac97_out_slot1_valid, ac97_out_slot1, ac97_out_slot2_valid, ac97_out_slot2};
    checks++;
    if (got_slots !== 42'h0) begin
      errors++;
      $display("FAIL %s_send_clear got %h exp 0", nm, got_slots);
    end
    if (w) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_timeout} !== {1'b1, 16'h0, 1'b0}) begin
        errors++;
        $display("FAIL %s_wr_rsp got v=%b d=%h t=%b exp v=1 d=0000 t=0", nm,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_timeout);
      end
      ed = 16'h0000; eto = 1'b0;
    end else begin
      model_read(a, ek, ed, eto);
      for (int k = 0; k <= ek; k++) begin
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_early_rsp got rsp_valid=1 before frame %0d exp 0", nm, k);
        end
        strobe(fr[k].tag, fr[k].s1, fr[k].s2, 1 + $urandom_range(0, 3));
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_timeout} !== {1'b1, ed, eto}) begin
        errors++;
        $display("FAIL %s_rd_rsp got v=%b d=%h t=%b exp v=1 d=%h t=%b (frame %0d)", nm,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_timeout, ed, eto, ek);
      end
    end
    idle(2);
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_timeout} !== {1'b0, ed, eto} ||
        rsp_cnt != pre + 1) begin
      errors++;
      $display("FAIL %s_after got v=%b d=%h t=%b pulses=%0d exp v=0 d=%h t=%b pulses=1", nm,
               bus.rsp_valid, bus.rsp_data, bus.rsp_timeout, rsp_cnt - pre, ed, eto);
    end
    checks++;
    if (bus.cmd_ready !== (w ? 1'b1 : fr[ek].tag[15])) begin
      errors++;
      $display("FAIL %s_cmd_ready got %b exp %b", nm, bus.cmd_ready, (w ? 1'b1 : fr[ek].tag[15]));
    end
  endtask

  task automatic test_reset;
    ac97_rst = 1'b1; ac97_strobe = 1'b1; ac97_in_tag = 16'hFFFF;
    repeat (2) @(negedge ac97_bitclk);
    ac97_strobe = 1'b0;
    checks++;
    if ({codec_ready, bus.cmd_ready, ac97_out_slot1_valid, ac97_out_slot2_valid, ac97_out_slot1,
         ac97_out_slot2, bus.rsp_valid, bus.rsp_data, bus.rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state got cr=%b rdy=%b s1v=%b s2v=%b s1=%h s2=%h rv=%b rd=%h rt=%b exp all 0",
               codec_ready, bus.cmd_ready, ac97_out_slot1_valid, ac97_out_slot2_valid,
               ac97_out_slot1, ac97_out_slot2, bus.rsp_valid, bus.rsp_data, bus.rsp_timeout);
    end
    ac97_rst = 1'b0;
    @(negedge ac97_bitclk);
  endtask

  task automatic test_not_ready;
    strobe(16'h6000, 20'h0, 20'h0, 2);
    checks++;
    if ({codec_ready, bus.cmd_ready} !== 2'b00) begin
      errors++;
      $display("FAIL nr_low got cr=%b rdy=%b exp 00", codec_ready, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 7'h05; bus.cmd_wdata = 16'h1234;
    idle(3);
    strobe(16'h0000, 20'h0, 20'h0, 1);
    idle(1);
    bus.cmd_valid = 1'b0;
    strobe(16'h0000, 20'h0, 20'h0, 2);
    checks++;
    if (ac97_out_slot1_valid !== 1'b0 || rsp_cnt != 0) begin
      errors++;
      $display("FAIL nr_ignored got s1v=%b pulses=%0d exp 0 0", ac97_out_slot1_valid, rsp_cnt);
    end
    strobe(16'h8000, 20'h0, 20'h0, 2);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL nr_ready got cmd_ready=%b exp 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write;
    run_txn(1'b1, 7'h02, 16'h8000, 1'b0, "wr_dir");
    checks++;
    if (bus.rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL wr_dir_data got %h exp 0000", bus.rsp_data);
    end
  endtask

  task automatic test_read_hit;
    fr[0] = '{16'hE000, 20'h7C000, 20'h41440};
    for (int i = 1; i < TO; i++) fr[i] = '{16'h8000, 20'h7C000, 20'h0};
    run_txn(1'b0, 7'h7C, 16'h0, 1'b0, "rd_hit");
    checks++;
    if ({bus.rsp_data, bus.rsp_timeout} !== {16'h4144, 1'b0}) begin
      errors++;
      $display("FAIL rd_hit_const got d=%h t=%b exp d=4144 t=0", bus.rsp_data, bus.rsp_timeout);
    end
  endtask

  task automatic test_read_timeout;
    for (int i = 0; i < TO; i++) fr[i] = '{16'h8000, 20'h26000, 20'h55550};
    run_txn(1'b0, 7'h26, 16'h0, 1'b0, "rd_to");
    checks++;
    if ({bus.rsp_data, bus.rsp_timeout} !== {16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL rd_to_const got d=%h t=%b exp d=FFFF t=1", bus.rsp_data, bus.rsp_timeout);
    end
  endtask

  task automatic test_addr_mismatch;
    fr[0] = '{16'hE000, 20'h24000, 20'h11110};
    fr[1] = '{16'hE000, 20'h24000, 20'h22220};
    fr[2] = '{16'hE000, 20'h26000, 20'hBEEF0};
    fr[3] = '{16'hE000, 20'h26000, 20'h33330};
    run_txn(1'b0, 7'h26, 16'h0, 1'b0, "rd_mis");
    // Match on the last allowed frame beats the timeout.
    for (int i = 0; i < TO - 1; i++) fr[i] = '{16'hE000, 20'h24000, 20'h44440};
    fr[TO-1] = '{16'hE000, 20'h26000, 20'hCAFE0};
    run_txn(1'b0, 7'h26, 16'h0, 1'b0, "rd_last");
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      logic [6:0] a = 7'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        run_txn(1'b1, a, 16'($urandom), 1'($urandom), "rnd_wr");
      end else begin
        for (int i = 0; i < TO; i++) begin
          fr[i].tag = {1'($urandom), ($urandom_range(0, 2) == 0), 14'($urandom)};
          fr[i].s1  = {1'($urandom), ($urandom_range(0, 1) == 0) ? a : 7'($urandom), 12'($urandom)};
          fr[i].s2  = 20'($urandom);
        end
        run_txn(1'b0, a, 16'($urandom), 1'($urandom), "rnd_rd");
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < TO; i++) fr[i] = '{16'hE000, 20'h11000, 20'h9ABC0};
    run_txn(1'b1, 7'h11, 16'h5A5A, 1'b1, "b2b_wr");
    run_txn(1'b0, 7'h11, 16'h0, 1'b1, "b2b_rd");
  endtask

  // where: 0 = reset while in SEND, 1 = reset while in WAIT.
  task automatic test_reset_mid(input int where);
    int pre;
    issue(1'b0, 7'h10, 16'h0, 1'b0, "rmid");
    strobe(16'h8000, 20'h0, 20'h0, 2);
    if (where == 1) begin
      strobe(16'h8000, 20'h0, 20'h0, 2);
      strobe(16'h8000, 20'h0, 20'h0, 2);
    end
    pre = rsp_cnt;
    ac97_rst = 1'b1; ac97_strobe = 1'b1; ac97_in_tag = 16'hE000; ac97_in_slot1 = 20'h10000;
    @(negedge ac97_bitclk);
    ac97_rst = 1'b0; ac97_strobe = 1'b0;
    checks++;
    if ({ac97_out_slot1_valid, ac97_out_slot2_valid, ac97_out_slot1, ac97_out_slot2,
         bus.rsp_valid, codec_ready, bus.cmd_ready} !== '0) begin
      errors++;
      $display("FAIL rmid%0d_state got s1v=%b s2v=%b s1=%h s2=%h rv=%b cr=%b rdy=%b exp all 0", where,
               ac97_out_slot1_valid, ac97_out_slot2_valid, ac97_out_slot1, ac97_out_slot2,
               bus.rsp_valid, codec_ready, bus.cmd_ready);
    end
    for (int i = 0; i < TO + 1; i++) strobe(16'h6000, 20'h10000, 20'h77770, 2);
    idle(2);
    checks++;
    if (rsp_cnt != pre || ac97_out_slot1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid%0d_norsp got pulses=%0d s1v=%b exp 0 0", where, rsp_cnt - pre,
               ac97_out_slot1_valid);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    @(negedge ac97_bitclk);
    test_reset();
    test_not_ready();
    test_write();
    test_read_hit();
    test_read_timeout();
    test_addr_mismatch();
    test_back_to_back();
    test_random();
    test_reset_mid(0);
    test_reset_mid(1);
    run_txn(1'b1, 7'h3A, 16'hC3C3, 1'b0, "post_rst_wr");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
